// File: rtl/programmable_divider.sv
// Programmable divide-by-N counter with a terminal flag and a hitless divisor reload.
// The square-wave output SQ is built only when PROGRAMMABLE_DIVIDER_SQUARE_OUT_EN is defined.
module programmable_divider #(
    parameter int WIDTH       = 4,
    parameter int DEFAULT_DIV = 6
) (
    input  logic             CLK,
    input  logic             CLEAR,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIV,
    input  logic             LOAD,
    output logic             LOAD_ACK,
    output logic [WIDTH-1:0] Count,
    output logic             OUT,
    output logic             SQ
);

    localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_N = WIDTH'(2);

    // Reload handshake: LOAD is a one-edge request that needs no ready.
    // The request sits in pend_div/pend_flag until the first wrap edge that
    // sees pend_flag already set; that edge swaps the divisor in, and the
    // single-cycle LOAD_ACK that follows marks it as active.
    logic [WIDTH-1:0] active_div;
    logic [WIDTH-1:0] pend_div;
    logic             pend_flag;

    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] div_next;
    logic             wrap;
    logic             apply;
    logic             out_next;

    always_comb begin
        load_val   = (DIV < MIN_N) ? MIN_N : DIV;
        wrap       = EN && (Count == active_div - WIDTH'(1));
        apply      = wrap && pend_flag;
        div_next   = apply ? pend_div : active_div;
        count_next = Count;
        if (EN) begin
            count_next = wrap ? '0 : Count + WIDTH'(1);
        end
        // Registered look-ahead so OUT rises on the same edge that loads N-1.
        out_next = (count_next == div_next - WIDTH'(1));
    end

    always_ff @(negedge CLK) begin
        if (CLEAR) begin
            Count      <= '0;
            OUT        <= 1'b0;
            LOAD_ACK   <= 1'b0;
            active_div <= DEF_N;
            pend_div   <= DEF_N;
            pend_flag  <= 1'b0;
        end else begin
            Count      <= count_next;
            OUT        <= out_next;
            LOAD_ACK   <= apply;
            active_div <= div_next;
            // A LOAD on the applying edge re-arms for the following wrap.
            if (LOAD) begin
                pend_div  <= load_val;
                pend_flag <= 1'b1;
            end else if (apply) begin
                pend_flag <= 1'b0;
            end
        end
    end

`ifdef PROGRAMMABLE_DIVIDER_SQUARE_OUT_EN
    logic [WIDTH:0] half_n;
    logic           sq_next;

    always_comb begin
        half_n  = ({1'b0, div_next} + (WIDTH+1)'(1)) >> 1;
        sq_next = ({1'b0, count_next} < half_n);
    end

    always_ff @(negedge CLK) begin
        if (CLEAR) begin
            SQ <= 1'b1;
        end else begin
            SQ <= sq_next;
        end
    end
`else
    assign SQ = 1'b0;
`endif

endmodule

// File: doc/programmable_divider.md
PROGRAMMABLE_DIVIDER -- requirements
Module: programmable_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: width of the counter and divisor in bits, legal range 2..16.
REQ-002 The block SHALL have parameter DEFAULT_DIV, default 6: the active divisor after reset, legal range 2..2^WIDTH-1.
REQ-003 Port CLK  input  1  is the only clock; all state SHALL update on the falling edge of CLK.
REQ-004 Port CLEAR  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Port EN  input  1  is the count enable; when high, the counter advances.
REQ-006 Port DIV  input  WIDTH  is the requested divisor N.
REQ-007 Port LOAD  input  1  is a single-cycle request to capture DIV.
REQ-008 Port LOAD_ACK  output  1  is a one-cycle pulse indicating that the captured divisor is now active.
REQ-009 Port Count  output  WIDTH  is the current counter state, range 0..N-1.
REQ-010 Port OUT  output  1  is the terminal-state flag; it is high while Count == N-1.
REQ-011 Port SQ  output  1  is the approximately 50% duty divided clock.

Function
REQ-012 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-013 With EN high at an edge, Count SHALL become Count+1 if Count < N-1, and 0 if Count == N-1 (wrap).
REQ-014 OUT SHALL be 1 in exactly the cycles where Count == N-1, i.e. one cycle in every N enabled cycles, asserted on the same edge that loads N-1.
REQ-015 SQ SHALL be 1 while Count < ceil(N/2) and 0 otherwise (N=6: high for counts 0-2; N=5: high for counts 0-2, low for 3-4).
REQ-016 With EN low, Count, OUT and SQ SHALL hold their values.
REQ-017 LOAD high at an edge SHALL capture DIV into a pending register and set a pending flag; this happens regardless of EN.
REQ-018 A captured DIV value of 0 or 1 SHALL be clamped to 2.
REQ-019 A pending divisor SHALL become active only on a wrap edge whose pending flag was already set before that edge; Count then restarts at 0 under the new N.
REQ-020 On that same wrap edge, the pending flag SHALL clear, and LOAD_ACK SHALL be 1 for exactly the following cycle.
REQ-021 A LOAD arriving while a divisor is already pending SHALL overwrite the pending value and produce only one LOAD_ACK.
REQ-022 A LOAD coinciding with a wrap edge SHALL be captured on that edge and applied at the next wrap, not the current one.
REQ-023 The active divisor SHALL never change mid-period, so OUT and SQ never produce a shortened or runt period.
REQ-024 Count SHALL never exceed N-1 for the active N.

Reset
REQ-025 CLEAR high at an edge SHALL force Count=0, OUT=0, SQ=1, LOAD_ACK=0, active N=DEFAULT_DIV, and pending flag=0.
REQ-026 CLEAR SHALL take priority over EN and LOAD; a LOAD asserted during CLEAR is discarded.
REQ-027 When CLEAR is asserted mid-period, no OUT or LOAD_ACK pulse SHALL be emitted for the interrupted period.

Configuration
REQ-028 The square-wave output SHALL be controlled by macro PROGRAMMABLE_DIVIDER_SQUARE_OUT_EN.
REQ-029 With PROGRAMMABLE_DIVIDER_SQUARE_OUT_EN defined, the SQ logic SHALL be compiled in and SHALL behave per REQ-015.
REQ-030 Without the macro, the SQ port SHALL remain present but be tied to 0, the SQ register and compare logic SHALL be omitted, and all other behaviour SHALL be unchanged.

Verification
REQ-031 Scenario: WIDTH=4, defaults, CLEAR 1 cycle, then EN=1 for 12 cycles -> Count sequence 1,2,3,4,5,0,1,2,3,4,5,0; OUT high only when Count=5; SQ high for counts 0-2.
REQ-032 Scenario: with N=6 and Count=2, pulse LOAD with DIV=3 -> Count continues 3,4,5, wraps to 0, then runs 0,1,2,0; LOAD_ACK high for exactly one cycle after the wrap.
REQ-033 Scenario: DIV=1 loaded, then DIV=0 loaded -> active N=2 in both cases; OUT toggles every enabled cycle.
REQ-034 Scenario: EN low for 5 cycles at Count=4 -> Count, OUT and SQ frozen; on EN=1, the next value is 5 with OUT=1.
REQ-035 Scenario: LOAD DIV=9 at Count=3, then LOAD DIV=4 at Count=4 -> after the wrap, N=4 and exactly one LOAD_ACK; LOAD on the wrap edge itself -> new N applies one period later.
REQ-036 Scenario: CLEAR asserted at Count=5 together with LOAD -> all outputs at reset values next cycle, N=6, no LOAD_ACK; with the macro undefined, SQ remains 0 throughout.
